// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   typedef enum logic {
      FETCH,
      HALTED
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic        fault;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between the memory response port and decode.
// Flush empties the buffer and takes priority over a push in the same cycle.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push,
   input  fetch_entry_t           push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output fetch_entry_t           head
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && !flush;
   assign do_pop  = pop && !flush && !empty;
   assign empty   = (count == '0);
   assign full    = (count == (AW + 1)'(DEPTH));
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (rst_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; entries are only observed through count, so stale contents are harmless.
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues in-order word fetches with credit-based
// flow control, buffers responses and hands them to decode with their PC.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT),
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   output logic                  imem_req_valid_o,
   input  logic                  imem_req_ready_i,
   output logic [DATA_WIDTH-1:0] imem_req_addr_o,
   input  logic                  imem_rsp_valid_i,
   input  logic [31:0]           imem_rsp_data_i,
   input  logic                  imem_rsp_err_i,
   input  logic                  redirect_valid_i,
   input  logic [DATA_WIDTH-1:0] redirect_pc_i,
   output logic                  instr_valid_o,
   input  logic                  instr_ready_i,
   output logic [31:0]           instr_o,
   output logic [DATA_WIDTH-1:0] instr_pc_o,
   output logic                  instr_fault_o
);

   localparam int                    CW         = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0]           CREDIT     = (CW + 1)'(FIFO_DEPTH);
   localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
   localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

   fetch_state_e          state;
   fetch_state_e          state_next;
   logic [DATA_WIDTH-1:0] req_pc;
   logic [DATA_WIDTH-1:0] deliver_pc;
   logic [DATA_WIDTH-1:0] target_pc;
   logic [CW-1:0]         inflight_cnt;
   logic [CW-1:0]         inflight_next;
   logic [CW-1:0]         drop_cnt;
   logic [CW-1:0]         drop_next;
   logic [CW-1:0]         fifo_cnt;
   logic [CW:0]           credit_used;
   logic                  req_fire;
   logic                  rsp_drop;
   logic                  rsp_push;
   logic                  pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   fetch_entry_t          rsp_entry;
   fetch_entry_t          head;

   assign target_pc   = redirect_pc_i & ALIGN_MASK;
   assign credit_used = {1'b0, inflight_cnt} + {1'b0, fifo_cnt};

   // Outstanding requests plus buffered entries never exceed the buffer, so every response has a slot.
   assign imem_req_valid_o = !rst_i && (state == FETCH) && !redirect_valid_i && (credit_used < CREDIT);
   assign imem_req_addr_o  = req_pc;
   assign req_fire         = imem_req_valid_o && imem_req_ready_i;

   assign rsp_drop  = redirect_valid_i || (drop_cnt != '0);
   assign rsp_push  = imem_rsp_valid_i && !rsp_drop;
   assign rsp_entry = '{fault: imem_rsp_err_i, instr: imem_rsp_data_i};

   assign instr_valid_o = !fifo_empty;
   assign pop           = instr_valid_o && instr_ready_i;
   assign instr_o       = instr_valid_o ? head.instr : '0;
   assign instr_fault_o = instr_valid_o && head.fault;
   assign instr_pc_o    = deliver_pc;

   fetch_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push     (rsp_push),
      .push_data(rsp_entry),
      .pop      (pop),
      .flush    (redirect_valid_i),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_cnt),
      .head     (head)
   );

   always_comb begin
      // NOTE: every signal gets a default first so no path through this block infers a latch.
      state_next    = state;
      inflight_next = inflight_cnt;
      drop_next     = drop_cnt;

      if (req_fire)         inflight_next = inflight_next + 1'b1;
      if (imem_rsp_valid_i) inflight_next = inflight_next - 1'b1;

      // On redirect every request still outstanding after this cycle becomes stale.
      if (redirect_valid_i) begin
         drop_next = inflight_next;
      end else if (imem_rsp_valid_i && (drop_cnt != '0)) begin
         drop_next = drop_cnt - 1'b1;
      end

      if (redirect_valid_i) begin
         state_next = FETCH;
      end else if ((state == FETCH) && rsp_push && imem_rsp_err_i) begin
         state_next = HALTED;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= FETCH;
         req_pc       <= RESET_PC;
         deliver_pc   <= RESET_PC;
         inflight_cnt <= '0;
         drop_cnt     <= '0;
      end else begin
         state        <= state_next;
         inflight_cnt <= inflight_next;
         drop_cnt     <= drop_next;
         if (redirect_valid_i) begin
            req_pc     <= target_pc;
            deliver_pc <= target_pc;
         end else begin
            if (req_fire) req_pc     <= req_pc + PC_STEP;
            if (pop)      deliver_pc <= deliver_pc + PC_STEP;
         end
      end
   end

   always @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(imem_rsp_valid_i && (inflight_cnt == '0)))
            else $error("fetch_unit: response with no request in flight");
         assert (!(rsp_push && fifo_full))
            else $error("fetch_unit: push into full instruction buffer");
      end
   end

endmodule
